// File: rtl/sha1_mm_pkg.sv
// Shared definitions for the SHA-1 Avalon-MM initiator.
//   - Register map of the SHA-1 slave (control/status, message, digest)
//   - Control/status bit positions
//   - FSM state encoding
package sha1_mm_pkg;

  localparam logic [4:0] CTRL_ADDR   = 5'd0;
  localparam logic [4:0] MSG_BASE    = 5'd1;
  localparam logic [4:0] DIGEST_BASE = 5'd17;

  localparam int unsigned START_BIT = 0;
  localparam int unsigned DONE_BIT  = 1;

  localparam int unsigned MSG_WORDS    = 16;
  localparam int unsigned DIGEST_WORDS = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_MSG,
    ST_WR_START,
    ST_POLL_WAIT,
    ST_POLL_RD,
    ST_RD_DIG,
    ST_RESP,
    ST_ABORT
  } state_t;

endpackage

// File: rtl/sha1_mm_initiator.sv
// Avalon-MM initiator driving the SHA-1 register-file slave.
// Accepts one pre-padded 512-bit block, writes it to addresses 1..16,
// writes START, polls DONE at address 0, reads the digest from 17..21
// and returns it on a valid/ready response port.
//
// Ports:
//   clk, reset_n                     clock, async active-low reset
//   req_valid/req_ready/req_block    request (512-bit block)
//   rsp_valid/rsp_ready/rsp_digest   response (160-bit digest)
//   rsp_error                        watchdog expiry, qualified by rsp_valid
//   busy                             FSM not idle
//   avm_*                            Avalon-MM master, zero-latency reads
//
// Optional feature: define SHA1_MM_TIMEOUT_EN to enable the poll watchdog
// (TIMEOUT_CYCLES). Without it polling never gives up and rsp_error is 0.
module sha1_mm_initiator
  import sha1_mm_pkg::*;
#(
  parameter int unsigned POLL_GAP       = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [511:0] req_block,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [159:0] rsp_digest,
  output logic         rsp_error,
  output logic         busy,
  output logic [4:0]   avm_address,
  output logic         avm_write,
  output logic         avm_read,
  output logic [31:0]  avm_writedata,
  input  logic [31:0]  avm_readdata
);

  state_t         r_state;
  state_t         w_next;
  logic           r_live;
  logic [511:0]   r_block;
  logic [3:0]     r_word;
  logic [31:0]    r_gap;
  logic [159:0]   r_digest;
  logic           w_hs;
  logic           w_timeout;
  logic [31:0]    w_msg_word;

  // r_live keeps req_ready low while reset is held and releases it on
  // the first clock edge afterwards.
  assign w_hs       = (r_state == ST_IDLE) && req_valid && r_live;
  assign w_msg_word = r_block[32*(MSG_WORDS-1-32'(r_word)) +: 32];
  assign rsp_digest = r_digest;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:      if (w_hs) w_next = ST_WR_MSG;
      ST_WR_MSG:    if (r_word == 4'd15) w_next = ST_WR_START;
      ST_WR_START:  w_next = (POLL_GAP == 0) ? ST_POLL_RD : ST_POLL_WAIT;
      ST_POLL_WAIT: begin
        if (w_timeout)                 w_next = ST_ABORT;
        else if (r_gap == POLL_GAP-1)  w_next = ST_POLL_RD;
      end
      ST_POLL_RD: begin
        // DONE wins over a watchdog expiry in the same cycle
        if (avm_readdata[DONE_BIT]) w_next = ST_RD_DIG;
        else if (w_timeout)         w_next = ST_ABORT;
        else                        w_next = (POLL_GAP == 0) ? ST_POLL_RD : ST_POLL_WAIT;
      end
      ST_RD_DIG:    if (r_word == 4'd4) w_next = ST_RESP;
      ST_RESP:      if (rsp_ready) w_next = ST_IDLE;
      ST_ABORT:     w_next = ST_RESP;
      default:      w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready     = 1'b0;
    rsp_valid     = 1'b0;
    busy          = (r_state != ST_IDLE);
    avm_address   = '0;
    avm_write     = 1'b0;
    avm_read      = 1'b0;
    avm_writedata = '0;
    case (r_state)
      ST_IDLE:     req_ready = r_live;
      ST_WR_MSG: begin
        avm_write     = 1'b1;
        avm_address   = MSG_BASE + 5'(r_word);
        avm_writedata = w_msg_word;
      end
      ST_WR_START: begin
        avm_write     = 1'b1;
        avm_address   = CTRL_ADDR;
        avm_writedata = 32'(1) << START_BIT;
      end
      ST_POLL_RD: begin
        avm_read    = 1'b1;
        avm_address = CTRL_ADDR;
      end
      ST_RD_DIG: begin
        avm_read    = 1'b1;
        avm_address = DIGEST_BASE + 5'(r_word);
      end
      ST_RESP:     rsp_valid = 1'b1;
      ST_ABORT: begin
        avm_write     = 1'b1;
        avm_address   = CTRL_ADDR;
        avm_writedata = '0;
      end
      default: ;
    endcase
  end

  // r_word runs 0..15 through the message writes and wraps to 0, so it
  // arrives at the digest reads already cleared.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_live   <= 1'b0;
      r_block  <= '0;
      r_word   <= '0;
      r_gap    <= '0;
      r_digest <= '0;
    end else begin
      r_live <= 1'b1;
      case (r_state)
        ST_IDLE: if (w_hs) begin
          r_block  <= req_block;
          r_digest <= '0;
          r_word   <= '0;
        end
        ST_WR_MSG:    r_word <= r_word + 4'd1;
        ST_WR_START:  r_gap  <= '0;
        ST_POLL_WAIT: r_gap  <= r_gap + 32'd1;
        ST_POLL_RD: begin
          r_gap  <= '0;
          r_word <= '0;
        end
        ST_RD_DIG: begin
          r_digest[32*(DIGEST_WORDS-1-32'(r_word)) +: 32] <= avm_readdata;
          r_word <= r_word + 4'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef SHA1_MM_TIMEOUT_EN
  logic [31:0] r_wdog;
  logic        r_error;

  assign w_timeout = ((r_state == ST_POLL_WAIT) || (r_state == ST_POLL_RD)) &&
                     (r_wdog == TIMEOUT_CYCLES - 1);
  assign rsp_error = r_error;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wdog  <= '0;
      r_error <= 1'b0;
    end else begin
      if (w_hs) r_error <= 1'b0;
      if (r_state == ST_ABORT) r_error <= 1'b1;
      if (r_state == ST_WR_START)
        r_wdog <= '0;
      else if ((r_state == ST_POLL_WAIT) || (r_state == ST_POLL_RD))
        r_wdog <= r_wdog + 32'd1;
    end
  end
`else
  logic w_unused_tmo;
  assign w_unused_tmo = ^TIMEOUT_CYCLES;
  assign w_timeout    = 1'b0;
  assign rsp_error    = 1'b0;
`endif

endmodule

// File: tb/tb_sha1_mm_initiator.sv
module tb_sha1_mm_initiator;

  localparam int unsigned GAP = 3;
  localparam int unsigned TMO = 64;

  localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [159:0] ABC_DIG = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         req_valid;
  logic         req_ready;
  logic [511:0] req_block;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [159:0] rsp_digest;
  logic         rsp_error;
  logic         busy;
  logic [4:0]   avm_address;
  logic         avm_write;
  logic         avm_read;
  logic [31:0]  avm_writedata;
  logic [31:0]  avm_readdata;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sha1_mm_initiator #(.POLL_GAP(GAP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_block(req_block),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_digest(rsp_digest),
    .rsp_error(rsp_error), .busy(busy),
    .avm_address(avm_address), .avm_write(avm_write), .avm_read(avm_read),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata)
  );

  // Reference SHA-1 compression of one block from the standard IV.
  function automatic logic [159:0] sha1_block(input logic [511:0] blk);
    logic [31:0] w [80];
    logic [31:0] a, b, c, d, e, f, k, t, x;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 80; i++) begin
      x = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
      w[i] = {x[30:0], x[31]};
    end
    a = 32'h67452301; b = 32'hEFCDAB89; c = 32'h98BADCFE;
    d = 32'h10325476; e = 32'hC3D2E1F0;
    for (int i = 0; i < 80; i++) begin
      if (i < 20)      begin f = (b & c) | (~b & d);         k = 32'h5A827999; end
      else if (i < 40) begin f = b ^ c ^ d;                  k = 32'h6ED9EBA1; end
      else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
      else             begin f = b ^ c ^ d;                  k = 32'hCA62C1D6; end
      t = {a[26:0], a[31:27]} + f + e + k + w[i];
      e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = t;
    end
    return {32'h67452301 + a, 32'hEFCDAB89 + b, 32'h98BADCFE + c,
            32'h10325476 + d, 32'hC3D2E1F0 + e};
  endfunction

  // ---------------- SHA-1 slave model ----------------
  logic [31:0]  s_msg [16];
  logic [511:0] s_cat;
  logic         s_done;
  int           s_cnt;
  logic [159:0] s_dig;
  bit           s_never  = 1'b0;
  bit           s_preset = 1'b0;
  int           s_lat    = 10;

  always_comb begin
    s_cat = '0;
    for (int i = 0; i < 16; i++) s_cat[511 - 32*i -: 32] = s_msg[i];
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_done <= 1'b0;
      s_cnt  <= 0;
      s_dig  <= '0;
      for (int i = 0; i < 16; i++) s_msg[i] <= '0;
    end else if (avm_write) begin
      if (avm_address >= 5'd1 && avm_address <= 5'd16)
        s_msg[int'(avm_address) - 1] <= avm_writedata;
      else if (avm_address == 5'd0) begin
        s_done <= 1'b0;
        s_cnt  <= avm_writedata[0] ? s_lat : 0;
      end
    end else if (s_preset) begin
      s_done <= 1'b1;
    end else if (s_cnt != 0) begin
      s_cnt <= s_cnt - 1;
      if (s_cnt == 1 && !s_never) begin
        s_done <= 1'b1;
        s_dig  <= sha1_block(s_cat);
      end
    end
  end

  always_comb begin
    avm_readdata = '0;
    if (avm_read) begin
      if (avm_address == 5'd0)       avm_readdata = {30'b0, s_done, 1'b0};
      else if (avm_address <= 5'd16) avm_readdata = s_msg[int'(avm_address) - 1];
      else if (avm_address <= 5'd21) avm_readdata = s_dig[159 - 32*(int'(avm_address) - 17) -: 32];
    end
  end

  // ---------------- bus monitor ----------------
  typedef struct {
    int          cyc;
    bit          wr;
    bit          rd;
    logic [4:0]  addr;
    logic [31:0] wd;
    logic [31:0] rdat;
  } txn_t;
  txn_t log_q[$];
  int   both_cnt = 0;
  int   idle_bad = 0;

  always @(posedge clk) begin
    if (reset_n) begin
      if (avm_write || avm_read) begin
        txn_t t;
        t.cyc = cyc; t.wr = avm_write; t.rd = avm_read;
        t.addr = avm_address; t.wd = avm_writedata; t.rdat = avm_readdata;
        log_q.push_back(t);
      end else if (avm_address != 5'd0 || avm_writedata != 32'd0) begin
        idle_bad++;
      end
      if (avm_write && avm_read) both_cnt++;
    end
  end

  // ---------------- drivers (no checking) ----------------
  task automatic start_job(input logic [511:0] blk, output int t_hs, output bit ok);
    ok = 1'b0; t_hs = -1;
    log_q.delete();
    req_block = blk; req_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (req_ready) begin ok = 1'b1; t_hs = cyc; break; end
      @(negedge clk);
    end
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 16; i++) req_block[32*i +: 32] = $urandom();
  endtask

  task automatic wait_rsp(input int limit, output int t_rsp, output bit ok);
    ok = 1'b0; t_rsp = -1;
    for (int i = 0; i < limit; i++) begin
      if (rsp_valid) begin ok = 1'b1; t_rsp = cyc; break; end
      @(negedge clk);
    end
  endtask

  task automatic finish_rsp(input int hold);
    repeat (hold) @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom();
    return b;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; req_block = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
    n_checks++;
    if ({rsp_valid, rsp_error, busy} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: rsp_valid/err/busy got %b want 000", {rsp_valid, rsp_error, busy});
    end
    n_checks++;
    if ({avm_write, avm_read, avm_address, avm_writedata} !== 39'd0 || rsp_digest !== 160'd0) begin
      n_fail++; $display("FAIL reset_bus: w=%b r=%b a=%0d wd=%h dig=%h want all 0",
                         avm_write, avm_read, avm_address, avm_writedata, rsp_digest);
    end
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL release_ready: req_ready=%b busy=%b want 1 0", req_ready, busy);
    end
  endtask

  task automatic test_abc();
    int t_hs, t_rsp; bit ok1, ok2;
    s_lat = 12;
    start_job(ABC_BLK, t_hs, ok1);
    wait_rsp(3000, t_rsp, ok2);
    n_checks++;
    if (!(ok1 && ok2)) begin n_fail++; $display("FAIL abc_timeout: accept=%b rsp=%b want 1 1", ok1, ok2); end
    n_checks++;
    if (rsp_digest !== ABC_DIG) begin n_fail++; $display("FAIL abc_digest: got %h want %h", rsp_digest, ABC_DIG); end
    n_checks++;
    if (rsp_error !== 1'b0) begin n_fail++; $display("FAIL abc_error: got %b want 0", rsp_error); end
    finish_rsp(0);
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL abc_return_idle: rsp_valid=%b req_ready=%b want 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_bus_sequence();
    int t_hs, t_rsp, j, p, expc; bit ok1, ok2;
    logic [511:0] blk;
    blk = rand_block();
    s_lat = int'($urandom_range(8, 30));
    start_job(blk, t_hs, ok1);
    wait_rsp(3000, t_rsp, ok2);
    n_checks++;
    if (!(ok1 && ok2) || log_q.size() < 23) begin
      n_fail++; $display("FAIL seq_complete: accept=%b rsp=%b txns=%0d want >=23", ok1, ok2, log_q.size());
      finish_rsp(0);
      return;
    end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (!(log_q[i].wr && log_q[i].addr == 5'(i + 1) && log_q[i].wd == blk[511 - 32*i -: 32] &&
            log_q[i].cyc == t_hs + 1 + i)) begin
        n_fail++; $display("FAIL seq_msg_write%0d: wr=%b addr=%0d data=%h cyc=%0d want addr %0d data %h cyc %0d",
                           i, log_q[i].wr, log_q[i].addr, log_q[i].wd, log_q[i].cyc, i + 1,
                           blk[511 - 32*i -: 32], t_hs + 1 + i);
      end
    end
    n_checks++;
    if (!(log_q[16].wr && log_q[16].addr == 5'd0 && log_q[16].wd == 32'h1 && log_q[16].cyc == t_hs + 17)) begin
      n_fail++; $display("FAIL seq_start: wr=%b addr=%0d data=%h cyc=%0d want addr 0 data 1 cyc %0d",
                         log_q[16].wr, log_q[16].addr, log_q[16].wd, log_q[16].cyc, t_hs + 17);
    end
    j = 17; p = -1; expc = t_hs + 18 + int'(GAP);
    while (j < log_q.size() && log_q[j].rd && log_q[j].addr == 5'd0) begin
      n_checks++;
      if (log_q[j].cyc != expc) begin
        n_fail++; $display("FAIL seq_poll_spacing: poll at cyc %0d want %0d", log_q[j].cyc, expc);
      end
      if (log_q[j].rdat[1]) begin p = log_q[j].cyc; j++; break; end
      expc += int'(GAP) + 1; j++;
    end
    n_checks++;
    if (p < 0 || log_q.size() != j + 5) begin
      n_fail++; $display("FAIL seq_tail: done_poll=%0d txns=%0d want %0d", p, log_q.size(), j + 5);
    end else begin
      for (int k = 0; k < 5; k++) begin
        n_checks++;
        if (!(log_q[j+k].rd && !log_q[j+k].wr && log_q[j+k].addr == 5'(17 + k) && log_q[j+k].cyc == p + 1 + k)) begin
          n_fail++; $display("FAIL seq_digest_read%0d: rd=%b addr=%0d cyc=%0d want addr %0d cyc %0d",
                             k, log_q[j+k].rd, log_q[j+k].addr, log_q[j+k].cyc, 17 + k, p + 1 + k);
        end
      end
      n_checks++;
      if (t_rsp != p + 6) begin n_fail++; $display("FAIL seq_rsp_cycle: got %0d want %0d", t_rsp, p + 6); end
    end
    n_checks++;
    if (rsp_digest !== sha1_block(blk)) begin
      n_fail++; $display("FAIL seq_digest: got %h want %h", rsp_digest, sha1_block(blk));
    end
    n_checks++;
    if (both_cnt != 0 || idle_bad != 0) begin
      n_fail++; $display("FAIL seq_strobes: both_high=%0d idle_nonzero=%0d want 0 0", both_cnt, idle_bad);
    end
    finish_rsp(0);
  endtask

  task automatic test_back_to_back();
    int t_hs, t_rsp, n0; bit ok1, ok2;
    s_lat = 9;
    start_job(ABC_BLK, t_hs, ok1);
    wait_rsp(3000, t_rsp, ok2);
    n_checks++;
    if (!(ok1 && ok2)) begin n_fail++; $display("FAIL bp_first_job: accept=%b rsp=%b want 1 1", ok1, ok2); end
    n0 = log_q.size();
    // a pending request during RESP must not be taken
    req_valid = 1'b1; req_block = ABC_BLK;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_digest !== ABC_DIG || req_ready !== 1'b0 ||
          avm_write !== 1'b0 || avm_read !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold%0d: valid=%b dig=%h req_ready=%b w=%b r=%b want 1 %h 0 0 0",
                           i, rsp_valid, rsp_digest, req_ready, avm_write, avm_read, ABC_DIG);
      end
    end
    n_checks++;
    if (log_q.size() != n0) begin n_fail++; $display("FAIL bp_bus_quiet: txns %0d want %0d", log_q.size(), n0); end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_release: req_ready=%b rsp_valid=%b want 1 0", req_ready, rsp_valid);
    end
    start_job(ABC_BLK, t_hs, ok1);
    wait_rsp(3000, t_rsp, ok2);
    n_checks++;
    if (!(ok1 && ok2) || rsp_digest !== ABC_DIG) begin
      n_fail++; $display("FAIL bp_second_job: ok=%b%b got %h want %h", ok1, ok2, rsp_digest, ABC_DIG);
    end
    finish_rsp(0);
  endtask

  task automatic test_stale_done();
    int t_hs, t_rsp, p; bit ok1, ok2;
    logic [511:0] blk;
    blk = rand_block();
    s_lat = 20;
    s_preset = 1'b1;
    @(negedge clk);
    s_preset = 1'b0;
    start_job(blk, t_hs, ok1);
    wait_rsp(3000, t_rsp, ok2);
    n_checks++;
    if (!(ok1 && ok2) || log_q.size() < 18) begin
      n_fail++; $display("FAIL stale_complete: accept=%b rsp=%b txns=%0d", ok1, ok2, log_q.size());
      finish_rsp(0);
      return;
    end
    n_checks++;
    if (!(log_q[17].rd && log_q[17].rdat[1] == 1'b0)) begin
      n_fail++; $display("FAIL stale_first_poll: rd=%b done=%b want 1 0", log_q[17].rd, log_q[17].rdat[1]);
    end
    p = t_rsp - 6;
    n_checks++;
    if (p < t_hs + 17 + s_lat + 1) begin
      n_fail++; $display("FAIL stale_early_done: done poll at %0d want >= %0d", p, t_hs + 18 + s_lat);
    end
    n_checks++;
    if (rsp_digest !== sha1_block(blk)) begin
      n_fail++; $display("FAIL stale_digest: got %h want %h", rsp_digest, sha1_block(blk));
    end
    finish_rsp(0);
  endtask

  task automatic test_random();
    int t_hs, t_rsp, td, pexp; bit ok1, ok2, early;
    logic [511:0] blk;
    for (int n = 0; n < 6; n++) begin
      blk   = rand_block();
      s_lat = int'($urandom_range(1, 40));
      early = n[0];
      rsp_ready = early;
      start_job(blk, t_hs, ok1);
      wait_rsp(3000, t_rsp, ok2);
      // DONE first visible in cycle td; first poll at or after it succeeds
      td   = t_hs + 18 + s_lat;
      pexp = t_hs + 18 + int'(GAP);
      while (pexp < td) pexp += int'(GAP) + 1;
      n_checks++;
      if (!(ok1 && ok2) || t_rsp != pexp + 6) begin
        n_fail++; $display("FAIL rand%0d_latency: ok=%b%b rsp at %0d want %0d", n, ok1, ok2, t_rsp, pexp + 6);
      end
      n_checks++;
      if (rsp_digest !== sha1_block(blk) || rsp_error !== 1'b0) begin
        n_fail++; $display("FAIL rand%0d_digest: got %h err %b want %h err 0", n, rsp_digest, rsp_error, sha1_block(blk));
      end
      finish_rsp(early ? 0 : int'($urandom_range(0, 4)));
      n_checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
        n_fail++; $display("FAIL rand%0d_idle: rsp_valid=%b req_ready=%b want 0 1", n, rsp_valid, req_ready);
      end
    end
  endtask

`ifdef SHA1_MM_TIMEOUT_EN
  task automatic test_timeout();
    int t_hs, t_rsp, aborts, last; bit ok1, ok2;
    s_never = 1'b1;
    s_lat   = 5;
    start_job(rand_block(), t_hs, ok1);
    wait_rsp(1000, t_rsp, ok2);
    n_checks++;
    if (!(ok1 && ok2)) begin n_fail++; $display("FAIL tmo_no_response: accept=%b rsp=%b want 1 1", ok1, ok2); end
    n_checks++;
    if (rsp_error !== 1'b1 || rsp_digest !== 160'd0) begin
      n_fail++; $display("FAIL tmo_result: err=%b dig=%h want 1 0", rsp_error, rsp_digest);
    end
    aborts = 0; last = -1;
    foreach (log_q[i]) begin
      if (log_q[i].wr && log_q[i].addr == 5'd0 && log_q[i].wd == 32'd0) begin aborts++; last = i; end
    end
    n_checks++;
    if (aborts != 1 || last != log_q.size() - 1 || log_q[last].cyc != t_hs + 18 + int'(TMO)) begin
      n_fail++; $display("FAIL tmo_abort_write: count=%0d cyc=%0d want 1 at %0d",
                         aborts, (last >= 0) ? log_q[last].cyc : -1, t_hs + 18 + int'(TMO));
    end
    finish_rsp(0);
    s_never = 1'b0;
  endtask
`endif

  task automatic test_reset_midjob();
    int t_hs, t_rsp; bit ok1, ok2, found;
    s_lat = 15;
    start_job(ABC_BLK, t_hs, ok1);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (avm_write && avm_address == 5'd8) begin found = 1'b1; break; end
      @(negedge clk);
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (!ok1 || !found) begin n_fail++; $display("FAIL midrst_word7: accept=%b seen=%b want 1 1", ok1, found); end
    n_checks++;
    if ({req_ready, rsp_valid, rsp_error, busy, avm_write, avm_read} !== 6'd0 ||
        avm_address !== 5'd0 || avm_writedata !== 32'd0 || rsp_digest !== 160'd0) begin
      n_fail++; $display("FAIL midrst_outputs: rdy=%b v=%b e=%b busy=%b w=%b r=%b a=%0d wd=%h want all 0",
                         req_ready, rsp_valid, rsp_error, busy, avm_write, avm_read, avm_address, avm_writedata);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    start_job(ABC_BLK, t_hs, ok1);
    wait_rsp(3000, t_rsp, ok2);
    n_checks++;
    if (!(ok1 && ok2) || rsp_digest !== ABC_DIG || rsp_error !== 1'b0) begin
      n_fail++; $display("FAIL midrst_fresh_job: ok=%b%b got %h err %b want %h err 0",
                         ok1, ok2, rsp_digest, rsp_error, ABC_DIG);
    end
    finish_rsp(0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_abc();
    test_bus_sequence();
    test_back_to_back();
    test_stale_done();
    test_random();
`ifdef SHA1_MM_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_midjob();
    n_checks++;
    if (both_cnt != 0 || idle_bad != 0) begin
      n_fail++; $display("FAIL strobe_rules: both_high=%0d idle_nonzero=%0d want 0 0", both_cnt, idle_bad);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
